// File: rtl/branch_resolver_pkg.sv
// Shared branch-type encodings, resolver state enum and decision helpers.
package branch_resolver_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } resolverState_t;

    // 010 and 011 are the only encodings with no branch meaning.
    function automatic logic isIllegal(input logic [2:0] f3);
        return f3[2:1] == 2'b01;
    endfunction

    // BLT/BGE compare as two's complement; everything else compares unsigned.
    function automatic logic isSigned(input logic [2:0] f3);
        return f3[2:1] == 2'b10;
    endfunction

    function automatic logic branchTaken(input logic [2:0] f3, input logic eq, input logic lt);
        logic t;
        t = 1'b0;
        case (f3)
            F3_BEQ:           t = eq;
            F3_BNE:           t = !eq;
            F3_BLT, F3_BLTU:  t = lt;
            F3_BGE, F3_BGEU:  t = !lt;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_resolver_digit_cmp.sv
// Unsigned magnitude compare of one DIGIT-wide slice.
//   a, b : digit of operand A and B
//   eq   : a == b
//   lt   : a <  b
module branch_digit_cmp #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             eq,
    output logic             lt
);

    assign eq = (a == b);
    assign lt = (a <  b);

endmodule

// File: rtl/branch_resolver.sv
// Multi-cycle branch resolver: compares rs1/rs2 one digit per cycle, MSB
// digit first, stopping at the first differing digit.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (ready only when idle)
//   funct3, rs1_data, rs2_data, pc, imm : branch request
//   out_valid / out_ready: result handshake (valid only when done)
//   br_eq, br_lt, taken, illegal, target : registered result
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            br_eq,
    output logic            br_lt,
    output logic            taken,
    output logic            illegal,
    output logic [XLEN-1:0] target
);

    localparam int unsigned NDIG = XLEN / DIGIT;
    localparam int unsigned KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(NDIG - 1);

    resolverState_t  stateQ, stateD;
    logic [KW-1:0]   kQ, kD;
    logic [2:0]      f3Q, f3D;
    logic [XLEN-1:0] aQ, aD, bQ, bD, targetQ, targetD;
    logic            eqQ, eqD, ltQ, ltD, takenQ, takenD, illegalQ, illegalD;

    logic [DIGIT-1:0] digitA, digitB;
    logic             digitEq, digitLt, signDiffer;

    // Single comparator shared across digits, selected by k.
    assign digitA = aQ[32'(kQ) * DIGIT +: DIGIT];
    assign digitB = bQ[32'(kQ) * DIGIT +: DIGIT];

    branch_digit_cmp #(.DIGIT(DIGIT)) uDigitCmp (
        .a  (digitA),
        .b  (digitB),
        .eq (digitEq),
        .lt (digitLt)
    );

    // Differing signs decide a signed compare outright; this holds from the
    // first SCAN cycle, so it always resolves there.
    assign signDiffer = isSigned(f3Q) && (aQ[XLEN-1] != bQ[XLEN-1]);

    // Next-state and result logic.
    always_comb begin
        stateD   = stateQ;
        kD       = kQ;
        f3D      = f3Q;
        aD       = aQ;
        bD       = bQ;
        targetD  = targetQ;
        eqD      = eqQ;
        ltD      = ltQ;
        takenD   = takenQ;
        illegalD = illegalQ;
        case (stateQ)
            IDLE: begin
                if (in_valid) begin
                    f3D      = funct3;
                    aD       = rs1_data;
                    bD       = rs2_data;
                    targetD  = pc + imm;
                    kD       = K_TOP;
                    eqD      = 1'b0;
                    ltD      = 1'b0;
                    takenD   = 1'b0;
                    illegalD = isIllegal(funct3);
                    stateD   = isIllegal(funct3) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (signDiffer) begin
                    eqD    = 1'b0;
                    ltD    = aQ[XLEN-1];
                    takenD = branchTaken(f3Q, 1'b0, aQ[XLEN-1]);
                    stateD = DONE;
                end else if (!digitEq) begin
                    eqD    = 1'b0;
                    ltD    = digitLt;
                    takenD = branchTaken(f3Q, 1'b0, digitLt);
                    stateD = DONE;
                end else if (kQ == '0) begin
                    eqD    = 1'b1;
                    ltD    = 1'b0;
                    takenD = branchTaken(f3Q, 1'b1, 1'b0);
                    stateD = DONE;
                end else begin
                    kD = kQ - KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= IDLE;
            kQ       <= K_TOP;
            f3Q      <= '0;
            aQ       <= '0;
            bQ       <= '0;
            targetQ  <= '0;
            eqQ      <= 1'b0;
            ltQ      <= 1'b0;
            takenQ   <= 1'b0;
            illegalQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            kQ       <= kD;
            f3Q      <= f3D;
            aQ       <= aD;
            bQ       <= bD;
            targetQ  <= targetD;
            eqQ      <= eqD;
            ltQ      <= ltD;
            takenQ   <= takenD;
            illegalQ <= illegalD;
        end
    end

    assign in_ready  = (stateQ == IDLE);
    assign out_valid = (stateQ == DONE);
    assign br_eq     = eqQ;
    assign br_lt     = ltQ;
    assign taken     = takenQ;
    assign illegal   = illegalQ;
    assign target    = targetQ;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
    import branch_resolver_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, pc, imm, target;
    logic        br_eq, br_lt, taken, illegal;

    always #5 clk = ~clk;

    branch_resolver #(.XLEN(32), .DIGIT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc(pc), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .br_eq(br_eq), .br_lt(br_lt), .taken(taken), .illegal(illegal),
        .target(target)
    );

    // lat = negedges from accept sample to first out_valid sample (SCAN cycles + 1)
    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b, pc, imm;
        logic        eq, lt, tk, ill;
        logic [31:0] tgt;
        int          lat;
        bit          hold;
    } vec_t;

    vec_t expQ[$];
    vec_t cur;
    vec_t vecs[10];
    int   errors = 0, checks = 0;
    int   cyc = 0, acceptCyc = 0;
    bit   have = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on each new result and checks it every DONE cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            have = 0;
        end else begin
            if (in_valid && in_ready) acceptCyc = cyc;
            if (out_valid) begin
                if (!have) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got out_valid=1 expected no result");
                    end else begin
                        cur  = expQ.pop_front();
                        have = 1;
                        check("latency", 32'(cyc - acceptCyc), 32'(cur.lat));
                    end
                end
                if (have) begin
                    check("br_eq",    {31'd0, br_eq},    {31'd0, cur.eq});
                    check("br_lt",    {31'd0, br_lt},    {31'd0, cur.lt});
                    check("taken",    {31'd0, taken},    {31'd0, cur.tk});
                    check("illegal",  {31'd0, illegal},  {31'd0, cur.ill});
                    check("target",   target,            cur.tgt);
                    check("in_ready_done", {31'd0, in_ready}, 32'd0);
                end
                if (out_ready) have = 0;
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        do begin @(negedge clk); n++; end while (!(in_ready && !out_valid) && n < 60);
        if (!(in_ready && !out_valid)) begin
            checks++; errors++;
            $display("FAIL wait_idle: got timeout expected idle");
        end
    endtask

    task automatic drive(input vec_t v);
        int n = 0;
        funct3 = v.f3; rs1_data = v.a; rs2_data = v.b; pc = v.pc; imm = v.imm;
        in_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!(in_valid && in_ready) && n < 60);
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept: got timeout expected in_ready");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input vec_t v);
        int n = 0;
        if (v.hold) begin
            waitIdle();
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        expQ.push_back(v);
        drive(v);
        if (v.hold) begin
            while (!out_valid && n < 60) begin @(negedge clk); n++; end
            if (!out_valid) begin
                checks++; errors++;
                $display("FAIL hold_wait: got timeout expected out_valid");
            end
            repeat (5) @(negedge clk);
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
    endtask

    initial begin
        vec_t v;
        int   n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        funct3 = '0; rs1_data = '0; rs2_data = '0; pc = '0; imm = '0;

        //          f3       a             b             pc            imm           eq   lt   tk   ill  tgt           lat hold
        vecs[0] = '{F3_BEQ,  32'h12345678, 32'h12345678, 32'h00001000, 32'h00000020, 1'b1,1'b0,1'b1,1'b0,32'h00001020, 9, 0};
        vecs[1] = '{F3_BLT,  32'hFFFFFFFF, 32'h00000001, 32'h00002000, 32'hFFFFFFF0, 1'b0,1'b1,1'b1,1'b0,32'h00001FF0, 2, 0};
        vecs[2] = '{F3_BLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00003000, 32'h00000004, 1'b0,1'b0,1'b0,1'b0,32'h00003004, 2, 0};
        vecs[3] = '{F3_BGEU, 32'h00010000, 32'h00020000, 32'hFFFFFFFC, 32'h00000008, 1'b0,1'b1,1'b0,1'b0,32'h00000004, 5, 0};
        vecs[4] = '{F3_BNE,  32'h12345678, 32'h12345679, 32'h00000100, 32'h00000000, 1'b0,1'b1,1'b1,1'b0,32'h00000100, 9, 0};
        vecs[5] = '{F3_BGE,  32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 1'b0,1'b1,1'b0,1'b0,32'h00000000, 2, 0};
        vecs[6] = '{F3_BGE,  32'h00000005, 32'hFFFFFFFD, 32'h00000010, 32'h00000010, 1'b0,1'b0,1'b1,1'b0,32'h00000020, 2, 0};
        vecs[7] = '{F3_BLT,  32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000040, 32'hFFFFFFFC, 1'b0,1'b1,1'b1,1'b0,32'h0000003C, 9, 0};
        vecs[8] = '{F3_BEQ,  32'h00000001, 32'h00000002, 32'h00000050, 32'h00000008, 1'b0,1'b1,1'b0,1'b0,32'h00000058, 9, 1};
        vecs[9] = '{3'b011,  32'h00000007, 32'h00000007, 32'h00000060, 32'h00000004, 1'b0,1'b0,1'b0,1'b1,32'h00000064, 1, 0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_flags",     {28'd0, br_eq, br_lt, taken, illegal}, 32'd0);
        check("rst_target",    target, 32'd0);

        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) issue(vecs[i]);

        // Reset mid-SCAN: the in-flight request must vanish.
        waitIdle();
        @(posedge clk); #1;
        v = '{F3_BEQ, 32'h12345678, 32'h12345678, 32'h0, 32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0, 0, 0};
        drive(v);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midscan_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midscan_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("midscan_rst_flags",     {28'd0, br_eq, br_lt, taken, illegal}, 32'd0);
        check("midscan_rst_target",    target, 32'd0);

        @(posedge clk); #1;
        v = '{3'b010, 32'h0, 32'h0, 32'h00000070, 32'h00000010, 1'b0,1'b0,1'b0,1'b1, 32'h00000080, 1, 0};
        issue(v);

        n = 0;
        while ((expQ.size() != 0 || have) && n < 100) begin @(negedge clk); n++; end
        check("queue_drained", 32'(expQ.size()), 32'd0);
        check("final_idle", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/PC width.
REQ-002 SHALL have parameter DIGIT, default 4, meaning bits compared per cycle; XLEN mod DIGIT = 0 required; NDIG = XLEN/DIGIT.
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have in_valid  input  1  request present.
REQ-006 SHALL have in_ready  output  1  request accepted when in_valid&&in_ready.
REQ-007 SHALL have funct3  input  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-008 SHALL have rs1_data, rs2_data  input  XLEN  operands A, B.
REQ-009 SHALL have pc, imm  input  XLEN  branch PC and sign-extended offset.
REQ-010 SHALL have out_valid  output  1  result present.
REQ-011 SHALL have out_ready  input  1  consumer accepts result.
REQ-012 SHALL have br_eq, br_lt, taken, illegal  output  1 each  A==B, A<B (signedness per funct3), branch decision, unsupported funct3.
REQ-013 SHALL have target  output  XLEN  pc+imm.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 On accept, SHALL register funct3, operands, and target=(pc+imm) mod 2^XLEN, set digit index k=NDIG-1, go to SCAN.
REQ-016 On accept with funct3 010 or 011, SHALL go directly to DONE with illegal=1, taken=0, br_eq=0, br_lt=0.
REQ-017 Unsigned mode (funct3[2:1]=11) SHALL compare digit k of A and B each SCAN cycle, MSB digit first.
REQ-018 Signed mode: if sign bits differ, SHALL resolve in the first SCAN cycle with br_lt=A[XLEN-1], br_eq=0; else identical to unsigned.
REQ-019 First differing digit SHALL end the scan: br_eq=0, br_lt=(digitA<digitB), next state DONE (early termination).
REQ-020 If digit k=0 is equal, SHALL set br_eq=1, br_lt=0, go to DONE; else k decrements, stays in SCAN.
REQ-021 SCAN latency SHALL be 1..NDIG cycles; DONE reached the cycle after the deciding SCAN cycle.
REQ-022 taken SHALL equal BEQ:eq, BNE:!eq, BLT/BLTU:lt, BGE/BGEU:!lt.
REQ-023 In DONE all outputs SHALL hold stable until out_valid&&out_ready, then return to IDLE; no new request accepted in that same cycle.
REQ-024 out_ready asserted outside DONE SHALL have no effect; in_valid outside IDLE SHALL be ignored.

Reset
REQ-025 rst SHALL force IDLE, k=NDIG-1, out_valid=0, in_ready=1 next cycle, br_eq=br_lt=taken=illegal=0, target=0, overriding any state including mid-SCAN and DONE.

Structure
REQ-026 Shared package SHALL hold funct3 branch constants and the state enum (IDLE/SCAN/DONE).
REQ-027 One sub-module branch_digit_cmp (DIGIT-wide, outputs eq, lt) SHALL be instantiated once and muxed by k.

Verification
REQ-028 BEQ A=B=0x12345678 -> 8 SCAN cycles, br_eq=1, taken=1, target=pc+imm.
REQ-029 BLT A=0xFFFFFFFF, B=0x00000001 -> 1 SCAN cycle, br_lt=1, taken=1; same operands BLTU -> 1 SCAN cycle, br_lt=0, taken=0.
REQ-030 BGEU A=0x00010000, B=0x00020000 -> resolves on digit 4 (4 SCAN cycles), taken=0; pc=0xFFFFFFFC, imm=8 -> target=0x00000004.
REQ-031 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; then accept -> IDLE.
REQ-032 rst pulsed mid-SCAN -> next cycle IDLE, out_valid=0, in_ready=1; funct3=010 -> DONE next cycle, illegal=1, taken=0.
